uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, 16, number of byte entries (power of two, 2..256).
REQ-002 SHALL have parameter AW, $clog2(DEPTH), pointer width; count width is AW+1.
REQ-003 SHALL have port clk  input  1  clock, all logic rising-edge.
REQ-004 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port wr_valid  input  1  producer offers a byte.
REQ-006 SHALL have port wr_data  input  8  byte offered.
REQ-007 SHALL have port wr_ready  output  1  FIFO can accept; equals !full.
REQ-008 SHALL have port flush  input  1  discard all stored bytes.
REQ-009 SHALL have port thresh  input  AW+1  low-water threshold.
REQ-010 SHALL have port ovf_clr  input  1  clears sticky overflow.
REQ-011 SHALL have port uart_enabled  input  1  downstream UART enable; gates draining.
REQ-012 SHALL have port uart_dat_we  output  1  write strobe to UART data register.
REQ-013 SHALL have port uart_dat_di  output  8  byte to UART data register.
REQ-014 SHALL have port uart_dat_wait  input  1  UART busy; write not accepted this cycle.
REQ-015 SHALL have ports level (output, AW+1, stored count), empty (output, 1), full (output, 1), overflow (output, 1, sticky), irq_low (output, 1, registered level<=thresh).

Function
REQ-016 Push SHALL occur on the cycle wr_valid && wr_ready && !flush; byte written at wr_ptr, wr_ptr wraps modulo DEPTH.
REQ-017 wr_ready SHALL depend only on registered count; a pop in the same cycle does not make a full FIFO accept.
REQ-018 Drain FSM SHALL have states IDLE, PRESENT, GAP.
REQ-019 IDLE -> PRESENT when !empty && uart_enabled; otherwise stay IDLE.
REQ-020 In PRESENT, uart_dat_we=1 and uart_dat_di=mem[rd_ptr], both stable until acceptance.
REQ-021 In PRESENT with uart_dat_wait=0 the byte SHALL be accepted: pop (rd_ptr+1 mod DEPTH, count-1), next state GAP.
REQ-022 In PRESENT with uart_dat_wait=1 SHALL stay PRESENT, no pop; uart_enabled deasserting does not abort PRESENT.
REQ-023 GAP SHALL last exactly one cycle with uart_dat_we=0, then IDLE.
REQ-024 Outside PRESENT uart_dat_we SHALL be 0; uart_dat_di is don't-care when uart_dat_we=0.
REQ-025 Latency: push at cycle N into empty FIFO with uart_enabled=1 SHALL yield uart_dat_we=1 at cycle N+2; back-to-back bytes spaced at least 3 cycles.
REQ-026 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-027 wr_valid while full SHALL drop the byte and set overflow; overflow clears on ovf_clr or flush; set has priority over ovf_clr in the same cycle.
REQ-028 flush SHALL, next cycle, zero pointers and count, force FSM to IDLE (abandoning PRESENT with no pop), clear overflow; flush has priority over push.
REQ-029 empty = (count==0), full = (count==DEPTH), level = count.
REQ-030 irq_low SHALL be registered: irq_low <= (count <= thresh) each cycle.

Reset
REQ-031 On resetn=0 at a clk edge: pointers=0, count=0, FSM=IDLE, overflow=0, irq_low=1; hence wr_ready=1, empty=1, full=0, level=0, uart_dat_we=0.
REQ-032 Reset mid-transfer SHALL abandon PRESENT with no pop and discard all content; storage array itself needs no reset.

Structure
REQ-033 Drain-FSM state encoding and default DEPTH SHALL live in a shared uart package used by the UART blocks.
REQ-034 Storage and pointer/count logic SHALL be one sub-module, uart_fifo_mem (sync write, async read of head); drain FSM stays in uart_tx_fifo.

Verification
REQ-035 Push 0x41 into empty FIFO, uart_enabled=1, wait=0 -> uart_dat_we=1 with 0x41 exactly 2 cycles later, one cycle long, then empty=1.
REQ-036 Push 0x10,0x20,0x30; hold uart_dat_wait=1 for 5 cycles -> uart_dat_we held with 0x10 stable, level=3; release -> 0x10,0x20,0x30 delivered in order, each separated by GAP.
REQ-037 uart_enabled=0, push 17 bytes with DEPTH=16 -> full=1, wr_ready=0, byte 17 dropped, overflow=1; ovf_clr -> overflow=0.
REQ-038 Fill 16 bytes, enable, keep wr_valid high -> push accepted the cycle after each pop, pointer wrap verified over 40 bytes, data order intact.
REQ-039 thresh=2, level 5 draining -> irq_low rises one cycle after level reaches 2.
REQ-040 flush (and separately resetn=0) while in PRESENT with wait=1 -> uart_dat_we=0 next cycle, level=0, no byte popped, subsequent push of 0x55 delivered normally.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks: drain-FSM encoding and default FIFO depth.
package uart_pkg;

  localparam int unsigned UART_FIFO_DEPTH = 16;

  typedef enum logic [1:0] {
    DRAIN_IDLE    = 2'd0,
    DRAIN_PRESENT = 2'd1,
    DRAIN_GAP     = 2'd2
  } drain_state_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Byte FIFO storage with write/read pointers and occupancy count.
// Synchronous write, asynchronous read of the head entry.
module uart_fifo_mem #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    wr_data,
  output logic [7:0]    rd_data,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers are AW bits wide, so DEPTH being a power of two makes the wrap implicit.
  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO feeding a UART data register: buffers producer bytes and drains
// them one at a time through a write strobe that honours the UART busy signal.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = UART_FIFO_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          wr_valid,
  input  logic [7:0]    wr_data,
  output logic          wr_ready,
  input  logic          flush,
  input  logic [AW:0]   thresh,
  input  logic          ovf_clr,
  input  logic          uart_enabled,
  output logic          uart_dat_we,
  output logic [7:0]    uart_dat_di,
  input  logic          uart_dat_wait,
  output logic [AW:0]   level,
  output logic          empty,
  output logic          full,
  output logic          overflow,
  output logic          irq_low
);

  drain_state_t state_q, state_d;
  logic         push;
  logic         pop;
  logic [AW:0]  count;
  logic [7:0]   head;

  // wr_ready comes from the registered count only, so a same-cycle pop never
  // lets a full FIFO accept.
  assign wr_ready = !full;
  assign push     = wr_valid && wr_ready && !flush;

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .resetn  (resetn),
    .flush   (flush),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_data),
    .rd_data (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      state_q <= DRAIN_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    uart_dat_we = 1'b0;
    unique case (state_q)
      DRAIN_IDLE: begin
        if (!empty && uart_enabled) state_d = DRAIN_PRESENT;
      end
      DRAIN_PRESENT: begin
        uart_dat_we = 1'b1;
        if (!uart_dat_wait) begin
          pop     = 1'b1;
          state_d = DRAIN_GAP;
        end
      end
      DRAIN_GAP: begin
        state_d = DRAIN_IDLE;
      end
      default: begin
        state_d = DRAIN_IDLE;
      end
    endcase
  end

  assign uart_dat_di = head;
  assign level       = count;

  // Setting wins over ovf_clr; flush and reset win over both.
  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      overflow <= 1'b0;
    end else if (wr_valid && full) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      irq_low <= 1'b1;
    end else begin
      irq_low <= (count <= thresh);
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed scenarios plus random traffic, all outputs
// compared each cycle against a queue-based model of the FIFO contents.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic          wr_valid;
  logic [7:0]    wr_data;
  logic          wr_ready;
  logic          flush;
  logic [AW:0]   thresh;
  logic          ovf_clr;
  logic          uart_enabled;
  logic          uart_dat_we;
  logic [7:0]    uart_dat_di;
  logic          uart_dat_wait;
  logic [AW:0]   level;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          irq_low;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .wr_valid      (wr_valid),
    .wr_data       (wr_data),
    .wr_ready      (wr_ready),
    .flush         (flush),
    .thresh        (thresh),
    .ovf_clr       (ovf_clr),
    .uart_enabled  (uart_enabled),
    .uart_dat_we   (uart_dat_we),
    .uart_dat_di   (uart_dat_di),
    .uart_dat_wait (uart_dat_wait),
    .level         (level),
    .empty         (empty),
    .full          (full),
    .overflow      (overflow),
    .irq_low       (irq_low)
  );

  int         checks = 0;
  int         errors = 0;
  bit         chk_en = 1'b0;
  logic [7:0] q[$];
  bit         m_ovf;
  bit         m_irq;
  bit         prev_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: compare outputs against the model just before the edge, then
  // advance the model by what the edge does, and return #1 after the edge.
  task automatic tick();
    bit acc;
    int sz;
    @(negedge clk);
    if (chk_en) begin
      chk("level", 32'(level), 32'(q.size()));
      chk("empty", 32'(empty), 32'(q.size() == 0));
      chk("full", 32'(full), 32'(q.size() == DEPTH));
      chk("wr_ready", 32'(wr_ready), 32'(q.size() != DEPTH));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("irq_low", 32'(irq_low), 32'(m_irq));
      if (q.size() == 0 || prev_acc) chk("we_quiet", 32'(uart_dat_we), 32'd0);
      if (uart_dat_we === 1'b1 && q.size() > 0) chk("dat_di", 32'(uart_dat_di), 32'(q[0]));
    end
    sz    = q.size();
    acc   = resetn && !flush && (uart_dat_we === 1'b1) && !uart_dat_wait;
    m_irq = !resetn ? 1'b1 : (sz <= int'(thresh));
    if (!resetn || flush) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      if (wr_valid && sz == DEPTH) m_ovf = 1'b1;
      else if (ovf_clr)            m_ovf = 1'b0;
      if (acc && sz > 0) void'(q.pop_front());
      if (wr_valid && sz < DEPTH) q.push_back(wr_data);
    end
    prev_acc = acc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int         n;
    int         nxt;
    int         delivered;
    bit         pushed;
    bit         accepted;
    logic [7:0] got [3];
    logic [7:0] gbyte;

    resetn = 1'b0; wr_valid = 1'b0; wr_data = '0; flush = 1'b0; thresh = '0;
    ovf_clr = 1'b0; uart_enabled = 1'b0; uart_dat_wait = 1'b0;
    tick();
    tick();
    resetn = 1'b1;

    chk("rst_level", 32'(level), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("rst_we", 32'(uart_dat_we), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_irq", 32'(irq_low), 32'd1);
    chk_en = 1'b1;

    // Single byte latency: strobe exactly two edges after the push, one cycle long.
    uart_enabled = 1'b1; uart_dat_wait = 1'b0;
    wr_valid = 1'b1; wr_data = 8'h41;
    tick();
    wr_valid = 1'b0;
    chk("lat_n1_we", 32'(uart_dat_we), 32'd0);
    tick();
    chk("lat_n2_we", 32'(uart_dat_we), 32'd1);
    chk("lat_n2_di", 32'(uart_dat_di), 32'h41);
    tick();
    chk("lat_n3_we", 32'(uart_dat_we), 32'd0);
    chk("lat_n3_empty", 32'(empty), 32'd1);
    tick();

    // UART busy holds the head byte; release delivers bytes in order with gaps.
    uart_dat_wait = 1'b1;
    wr_valid = 1'b1;
    wr_data = 8'h10; tick();
    wr_data = 8'h20; tick();
    wr_data = 8'h30; tick();
    wr_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("hold_we", 32'(uart_dat_we), 32'd1);
      chk("hold_di", 32'(uart_dat_di), 32'h10);
      chk("hold_level", 32'(level), 32'd3);
      tick();
    end
    uart_dat_wait = 1'b0;
    n = 0;
    for (int c = 0; c < 40 && n < 3; c++) begin
      if (uart_dat_we === 1'b1) begin
        got[n] = uart_dat_di;
        n++;
      end
      tick();
    end
    chk("rel_count", 32'(n), 32'd3);
    chk("rel_b0", 32'(got[0]), 32'h10);
    chk("rel_b1", 32'(got[1]), 32'h20);
    chk("rel_b2", 32'(got[2]), 32'h30);
    tick();

    // Overfill with draining disabled: 17th byte dropped, sticky overflow.
    uart_enabled = 1'b0;
    for (int i = 0; i < 17; i++) begin
      wr_valid = 1'b1; wr_data = 8'(i);
      tick();
    end
    wr_valid = 1'b0;
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_wr_ready", 32'(wr_ready), 32'd0);
    chk("ovf_level", 32'(level), 32'd16);
    chk("ovf_set", 32'(overflow), 32'd1);
    tick();
    chk("ovf_sticky", 32'(overflow), 32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'd0);
    chk("ovf_clr_level", 32'(level), 32'd16);

    // Full FIFO (0..15) drained while producer keeps offering: 40 bytes through the wrap.
    uart_enabled = 1'b1; uart_dat_wait = 1'b0;
    nxt = 16; delivered = 0;
    for (int c = 0; c < 400 && delivered < 40; c++) begin
      wr_valid = (nxt < 40);
      wr_data  = 8'(nxt);
      pushed   = wr_valid && (wr_ready === 1'b1);
      accepted = (uart_dat_we === 1'b1) && !uart_dat_wait;
      gbyte    = uart_dat_di;
      tick();
      if (pushed) nxt++;
      if (accepted) begin
        chk("wrap_order", 32'(gbyte), 32'(delivered));
        delivered++;
      end
    end
    wr_valid = 1'b0;
    chk("wrap_delivered", 32'(delivered), 32'd40);
    chk("wrap_pushed", 32'(nxt), 32'd40);
    chk("wrap_empty", 32'(empty), 32'd1);
    tick(); tick();

    // Low-water interrupt: rises one edge after level reaches the threshold.
    uart_enabled = 1'b0; thresh = 5'd2;
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1; wr_data = 8'(8'hA0 + i);
      tick();
    end
    wr_valid = 1'b0;
    tick();
    chk("irq_hi_level", 32'(irq_low), 32'd0);
    uart_enabled = 1'b1;
    for (int c = 0; c < 100 && level !== 5'd2; c++) tick();
    chk("irq_at2_level", 32'(level), 32'd2);
    chk("irq_at2_irq", 32'(irq_low), 32'd0);
    tick();
    chk("irq_rise", 32'(irq_low), 32'd1);
    for (int i = 0; i < 10; i++) tick();

    // Abandon a held transfer: flush, then reset; a later byte flows normally.
    for (int v = 0; v < 2; v++) begin
      uart_enabled = 1'b1; uart_dat_wait = 1'b1;
      wr_valid = 1'b1; wr_data = 8'h77;
      tick();
      wr_valid = 1'b0;
      tick();
      chk("abort_pre_we", 32'(uart_dat_we), 32'd1);
      chk("abort_pre_di", 32'(uart_dat_di), 32'h77);
      if (v == 0) flush = 1'b1; else resetn = 1'b0;
      tick();
      flush = 1'b0; resetn = 1'b1;
      chk("abort_we", 32'(uart_dat_we), 32'd0);
      chk("abort_level", 32'(level), 32'd0);
      chk("abort_ovf", 32'(overflow), 32'd0);
      uart_dat_wait = 1'b0;
      wr_valid = 1'b1; wr_data = 8'h55;
      tick();
      wr_valid = 1'b0;
      tick();
      chk("after_we", 32'(uart_dat_we), 32'd1);
      chk("after_di", 32'(uart_dat_di), 32'h55);
      tick();
      chk("after_empty", 32'(empty), 32'd1);
      tick();
    end

    // Random traffic against the queue model.
    for (int c = 0; c < 3000; c++) begin
      wr_valid      = ($urandom_range(0, 2) != 0);
      wr_data       = 8'($urandom);
      uart_enabled  = ($urandom_range(0, 7) != 0);
      uart_dat_wait = ($urandom_range(0, 2) == 0);
      flush         = ($urandom_range(0, 60) == 0);
      ovf_clr       = ($urandom_range(0, 15) == 0);
      resetn        = ($urandom_range(0, 150) != 0);
      thresh        = 5'($urandom_range(0, DEPTH));
      tick();
    end
    resetn = 1'b1; flush = 1'b0; wr_valid = 1'b0; ovf_clr = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
